uart_tx_engine: RTL
===================

// Module: uart_tx_engine
// PURPOSE
//  Serialises one user byte per valid/ready handshake into an asynchronous UART frame on o_uart_tx.
//  Frame = start, data LSB-first, optional parity, stop.
//  Runs entirely on i_clk. The baud timing comes from an internal per-bit counter, not a divided clock.
//  Transmit-side companion to the UART receive path; uses the same frame parameters so both ends agree.
// PARAMETERS
//  P_SYSTEM_CLK        100000000  i_clk frequency, Hz
//  P_UART_BUADRATE     115200     line rate; bit period DIV = P_SYSTEM_CLK/P_UART_BUADRATE (868); DIV>=2 required
//  P_UART_START_WIDTH  1          start bits (line low)
//  P_UART_DATA_WIDTH   8          data bits, LSB first
//  P_UART_STOP_WIDTH   1          stop bits (line high)
//  P_UART_CHECK_WIDTH  1          0 = no parity bit, 1 = one parity bit
//  P_UART_CHECK        1          0 = even parity, 1 = odd parity
// PORTS
//  i_clk            in   1    system clock
//  i_rst            in   1    asynchronous reset, active-high
//  o_uart_tx        out  1    serial line, idle high
//  i_user_tx_data   in   DW   byte to send (DW = P_UART_DATA_WIDTH)
//  i_user_tx_valid  in   1    data valid
//  o_user_tx_ready  out  1    engine can accept; transfer when valid && ready at a rising edge
//  o_tx_busy        out  1    high from the accept edge until the frame's last stop bit completes
// BEHAVIOUR
//  Reset values (async, immediate):
//   - o_uart_tx = 1, o_user_tx_ready = 0, o_tx_busy = 0.
//   - State IDLE; all counters and the shift register are 0.
//   - ready rises on the first i_clk edge after i_rst deasserts.
//  FSM: IDLE -> START -> DATA -> [CHECK if P_UART_CHECK_WIDTH==1] -> STOP -> IDLE.
//  Bit timing:
//   - Every line bit is held exactly DIV i_clk cycles; the bit counter wraps DIV-1 -> 0.
//   - Multi-bit START and STOP phases count bits separately.
//  Accept edge:
//   - On the accept edge, data is copied to the shift register; later changes on i_user_tx_data are ignored.
//   - Registered outputs on that same edge: o_uart_tx = 0, ready = 0, busy = 1, state = START.
//   - Latency from accept to the start bit on the line is one edge.
//  Line values per state:
//   - DATA: o_uart_tx = shift[0]; shift right once per bit.
//   - CHECK, even: ^data. CHECK, odd: ~^data. Parity is computed on the captured byte.
//   - STOP: o_uart_tx = 1.
//  Frame end:
//   - On the edge ending the last stop bit: state = IDLE, busy = 0, ready = 1, line stays high.
//   - Frame length = (START + DW + CHECK_WIDTH + STOP) * DIV cycles (default 11 * 868 = 9548).
//   - Back-to-back (valid held high): the next start bit begins 1 cycle after the frame ends (1-cycle idle gap).
//  Valid while ready = 0: ignored, not latched, no error. Upstream must hold data until accepted.
//  Reset mid-frame: the line returns high immediately and the partial frame is dropped. No resend.
// CONFIGURATION
//  UART_TX_HOLD_EN defined:
//   - Adds a one-entry holding register.
//   - ready = hold register empty, including while a frame is in flight.
//   - A byte accepted while busy is stored in the holding register.
//   - At the last stop-bit edge with hold full: go directly STOP -> START (no idle cycle), move hold into shift, ready = 1.
//   - Reset clears hold.
//  UART_TX_HOLD_EN undefined:
//   - No holding register; ready = (state == IDLE) as above.
// TESTING
//  1. Defaults, send 0x55 -> line 0,1,0,1,0,1,0,1,0,par=1,1; each bit 868 cycles; ready low 9548 cycles.
//  2. P_UART_CHECK=0: 0xFF gives par=0, 0x01 gives par=1. P_UART_CHECK=1: 0x00 gives par=1.
//  3. Valid held high with 0xA5 then 0x3C, no HOLD -> exactly 1 high cycle between stop end and the next start.
//     With UART_TX_HOLD_EN -> 0-cycle gap; the second byte is accepted 1 cycle after the first.
//  4. No HOLD: pulse valid with 0x12 mid-frame while sending 0x34 -> 0x12 never appears; line carries only 0x34.
//  5. Assert i_rst during data bit 3 of 0x81 -> line high the same cycle.
//     After release, send 0x81 -> one clean frame, correct parity.
//  6. P_UART_CHECK_WIDTH=0, P_UART_STOP_WIDTH=2, send 0xC3 -> 11-bit frame with no parity bit and 2*868 high stop cycles.

Source files
------------

// File: rtl/uart_tx_engine.sv
// UART transmit engine: one byte per valid/ready handshake, start / LSB-first data / optional parity / stop.
// Define UART_TX_HOLD_EN to add a one-entry holding register so frames can run back-to-back with no idle cycle.
module uart_tx_engine #(
   parameter int P_SYSTEM_CLK       = 100000000,
   parameter int P_UART_BUADRATE    = 115200,
   parameter int P_UART_START_WIDTH = 1,
   parameter int P_UART_DATA_WIDTH  = 8,
   parameter int P_UART_STOP_WIDTH  = 1,
   parameter int P_UART_CHECK_WIDTH = 1,
   parameter int P_UART_CHECK       = 1
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   output logic                         o_uart_tx,
   input  logic [P_UART_DATA_WIDTH-1:0] i_user_tx_data,
   input  logic                         i_user_tx_valid,
   output logic                         o_user_tx_ready,
   output logic                         o_tx_busy
);

   localparam int DIV      = P_SYSTEM_CLK / P_UART_BUADRATE;
   localparam int CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int MAX_A    = (P_UART_START_WIDTH > P_UART_DATA_WIDTH) ? P_UART_START_WIDTH : P_UART_DATA_WIDTH;
   localparam int MAX_BITS = (MAX_A > P_UART_STOP_WIDTH) ? MAX_A : P_UART_STOP_WIDTH;
   localparam int BIT_W    = $clog2(MAX_BITS + 1);
   localparam int DW       = P_UART_DATA_WIDTH;

   localparam logic [CNT_W-1:0] BAUD_LAST  = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] BAUD_ONE   = CNT_W'(1);
   localparam logic [BIT_W-1:0] BIT_ONE    = BIT_W'(1);
   localparam logic [BIT_W-1:0] START_LAST = BIT_W'(P_UART_START_WIDTH - 1);
   localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(P_UART_DATA_WIDTH - 1);
   localparam logic [BIT_W-1:0] STOP_LAST  = BIT_W'(P_UART_STOP_WIDTH - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_CHECK,
      ST_STOP
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  baud_cnt_q, baud_cnt_d;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [DW-1:0]     shift_q, shift_d;
   logic              parity_q, parity_d;
   logic              tx_q, tx_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;
`ifdef UART_TX_HOLD_EN
   logic [DW-1:0]     hold_q, hold_d;
   logic              hold_full_q, hold_full_d;
`endif

   logic              accept;
   logic              bit_end;
   logic              launch;
   logic [DW-1:0]     launch_data;
   logic [DW-1:0]     shifted;

   function automatic logic parity_of(input logic [DW-1:0] d);
      return (P_UART_CHECK != 0) ? ~^d : ^d;
   endfunction

   assign accept  = i_user_tx_valid && ready_q;
   assign bit_end = (baud_cnt_q == BAUD_LAST);
   assign shifted = shift_q >> 1;

   always_comb begin
      state_d     = state_q;
      baud_cnt_d  = baud_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      parity_d    = parity_q;
      tx_d        = tx_q;
      busy_d      = busy_q;
      launch      = 1'b0;
      launch_data = i_user_tx_data;
`ifdef UART_TX_HOLD_EN
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
`endif

      if (state_q != ST_IDLE) begin
         baud_cnt_d = bit_end ? '0 : baud_cnt_q + BAUD_ONE;
      end

      case (state_q)
         ST_IDLE: begin
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
`ifdef UART_TX_HOLD_EN
            if (hold_full_q) begin
               launch      = 1'b1;
               launch_data = hold_q;
               hold_full_d = 1'b0;
            end else if (accept) begin
               launch = 1'b1;
            end
`else
            launch = accept;
`endif
         end
         ST_START: begin
            if (bit_end) begin
               if (bit_cnt_q == START_LAST) begin
                  bit_cnt_d = '0;
                  state_d   = ST_DATA;
                  tx_d      = shift_q[0];
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_ONE;
               end
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               shift_d = shifted;
               if (bit_cnt_q == DATA_LAST) begin
                  bit_cnt_d = '0;
                  if (P_UART_CHECK_WIDTH == 1) begin
                     state_d = ST_CHECK;
                     tx_d    = parity_q;
                  end else begin
                     state_d = ST_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_ONE;
                  tx_d      = shifted[0];
               end
            end
         end
         ST_CHECK: begin
            if (bit_end) begin
               state_d   = ST_STOP;
               tx_d      = 1'b1;
               bit_cnt_d = '0;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               if (bit_cnt_q == STOP_LAST) begin
                  state_d   = ST_IDLE;
                  busy_d    = 1'b0;
                  tx_d      = 1'b1;
                  bit_cnt_d = '0;
`ifdef UART_TX_HOLD_EN
                  if (hold_full_q) begin
                     launch      = 1'b1;
                     launch_data = hold_q;
                     hold_full_d = 1'b0;
                  end
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_ONE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Parity is fixed at launch so later data changes cannot affect the frame
      if (launch) begin
         shift_d    = launch_data;
         parity_d   = parity_of(launch_data);
         tx_d       = 1'b0;
         busy_d     = 1'b1;
         state_d    = ST_START;
         bit_cnt_d  = '0;
         baud_cnt_d = '0;
      end

`ifdef UART_TX_HOLD_EN
      if (accept && state_q != ST_IDLE) begin
         hold_d      = i_user_tx_data;
         hold_full_d = 1'b1;
      end
      ready_d = !hold_full_d;
`else
      ready_d = (state_d == ST_IDLE);
`endif
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         baud_cnt_q  <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         parity_q    <= 1'b0;
         tx_q        <= 1'b1;
         ready_q     <= 1'b0;
         busy_q      <= 1'b0;
`ifdef UART_TX_HOLD_EN
         hold_q      <= '0;
         hold_full_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         baud_cnt_q  <= baud_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         parity_q    <= parity_d;
         tx_q        <= tx_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
`ifdef UART_TX_HOLD_EN
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
`endif
      end
   end

   assign o_uart_tx       = tx_q;
   assign o_user_tx_ready = ready_q;
   assign o_tx_busy       = busy_q;

endmodule
